// File: rtl/led_blink_tx.sv
// Blink sequencer: on request emits N lit/dark pulse pairs, then a trailing dark gap,
// then a one-cycle completion pulse. Outputs are registered and change on the accepting edge.
module led_blink_tx #(
  parameter int ON_CYCLES  = 5_000_000,
  parameter int OFF_CYCLES = 5_000_000,
  parameter int GAP_CYCLES = 15_000_000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [3:0] i_count,
  output logic       o_led,
  output logic       o_busy,
  output logic       o_done
);

  localparam int MAX_ONOFF = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int MAX_C     = (MAX_ONOFF > GAP_CYCLES) ? MAX_ONOFF : GAP_CYCLES;
  // Timer counts 0..(phase length - 1), so it never needs to hold MAX_C itself.
  localparam int TW        = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(OFF_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_GAP} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [3:0]      cnt_q,   cnt_d;
  logic            led_q,   led_d;
  logic            busy_q,  busy_d;
  logic            done_q,  done_d;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    led_d   = led_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          timer_d = '0;
          busy_d  = 1'b1;
          if (i_count != 4'd0) begin
            state_d = S_ON;
            cnt_d   = i_count;
            led_d   = 1'b1;
          end else begin
            state_d = S_GAP;
            led_d   = 1'b0;
          end
        end
      end
      S_ON: begin
        if (timer_q == ON_LAST) begin
          timer_d = '0;
          state_d = S_OFF;
          led_d   = 1'b0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_OFF: begin
        if (timer_q == OFF_LAST) begin
          timer_d = '0;
          cnt_d   = cnt_q - 4'd1;
          // Test the pre-decrement value so a count of 15 never aliases to 0.
          if (cnt_q == 4'd1) begin
            state_d = S_GAP;
          end else begin
            state_d = S_ON;
            led_d   = 1'b1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_GAP: begin
        if (timer_q == GAP_LAST) begin
          timer_d = '0;
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
        cnt_d   = '0;
        led_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      cnt_q   <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_led  = led_q;
  assign o_busy = busy_q;
  assign o_done = done_q;

endmodule

// File: tb/tb_led_blink_tx.sv
// Directed bench for led_blink_tx with ON=3, OFF=2, GAP=4; outputs sampled on the falling edge.
module tb_led_blink_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       i_start = 1'b0;
  logic [3:0] i_count = 4'd0;
  logic       o_led, o_busy, o_done;

  int n_cmp = 0;
  int n_bad = 0;

  led_blink_tx #(.ON_CYCLES(3), .OFF_CYCLES(2), .GAP_CYCLES(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_count(i_count),
    .o_led(o_led), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  // Request a sequence; returns at the falling edge after the accepting edge.
  task automatic start_seq(input logic [3:0] n);
    @(negedge clk);
    i_start = 1'b1;
    i_count = n;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  // Samples from the current falling edge until o_done is seen or budget runs out.
  task automatic observe(input int budget, input int poke_at, input logic [3:0] poke_cnt,
                         output int busy_n, output int blinks, output logic [127:0] pat,
                         output bit got_done);
    logic prev;
    busy_n = 0; blinks = 0; pat = '0; got_done = 1'b0; prev = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (o_busy) busy_n++;
      if (i < 128) pat[i] = o_led;
      if (o_led && !prev) blinks++;
      prev = o_led;
      if (o_done) begin
        got_done = 1'b1;
        break;
      end
      if (i == poke_at) begin
        i_start = 1'b1;
        i_count = poke_cnt;
      end else begin
        i_start = 1'b0;
      end
      @(negedge clk);
    end
    i_start = 1'b0;
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    #1;
    n_cmp++; if ({o_led, o_busy, o_done} !== 3'b000) begin n_bad++;
      $display("FAIL reset_outputs got=%b want=000", {o_led, o_busy, o_done}); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if ({o_led, o_busy, o_done} !== 3'b000) begin n_bad++;
      $display("FAIL idle_after_reset got=%b want=000", {o_led, o_busy, o_done}); end
  endtask

  task automatic test_two_blinks;
    int busy_n, blinks; logic [127:0] pat; bit got;
    start_seq(4'd2);
    observe(40, -1, 4'd0, busy_n, blinks, pat, got);
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL two_done_timeout got=%0d want=1", got); end
    n_cmp++; if (pat[14:0] !== 15'h00E7) begin n_bad++;
      $display("FAIL two_led_pattern got=%h want=00e7", pat[14:0]); end
    n_cmp++; if (busy_n !== 14) begin n_bad++; $display("FAIL two_busy_len got=%0d want=14", busy_n); end
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL two_busy_at_done got=%b want=0", o_busy); end
    @(negedge clk);
    n_cmp++; if (o_done !== 1'b0) begin n_bad++; $display("FAIL two_done_width got=%b want=0", o_done); end
  endtask

  task automatic test_zero_count;
    int busy_n, blinks; logic [127:0] pat; bit got;
    start_seq(4'd0);
    observe(40, -1, 4'd0, busy_n, blinks, pat, got);
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL zero_done_timeout got=%0d want=1", got); end
    n_cmp++; if (pat !== '0) begin n_bad++; $display("FAIL zero_led got=%h want=0", pat); end
    n_cmp++; if (busy_n !== 4) begin n_bad++; $display("FAIL zero_busy_len got=%0d want=4", busy_n); end
  endtask

  task automatic test_ignore_start;
    int busy_n, blinks; logic [127:0] pat; bit got;
    start_seq(4'd1);
    observe(40, 1, 4'd9, busy_n, blinks, pat, got);
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL ign_done_timeout got=%0d want=1", got); end
    n_cmp++; if (blinks !== 1) begin n_bad++; $display("FAIL ign_blinks got=%0d want=1", blinks); end
    n_cmp++; if (busy_n !== 9) begin n_bad++; $display("FAIL ign_busy_len got=%0d want=9", busy_n); end
    repeat (5) begin
      @(negedge clk);
      n_cmp++; if ({o_busy, o_done} !== 2'b00) begin n_bad++;
        $display("FAIL ign_quiet_after got=%b want=00", {o_busy, o_done}); end
    end
  endtask

  task automatic test_async_reset;
    int busy_n, blinks; logic [127:0] pat; bit got;
    start_seq(4'd3);
    repeat (5) @(negedge clk);
    n_cmp++; if ({o_led, o_busy} !== 2'b11) begin n_bad++;
      $display("FAIL rst_second_on got=%b want=11", {o_led, o_busy}); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({o_led, o_busy, o_done} !== 3'b000) begin n_bad++;
      $display("FAIL rst_async_drop got=%b want=000", {o_led, o_busy, o_done}); end
    repeat (3) begin
      @(negedge clk);
      n_cmp++; if (o_done !== 1'b0) begin n_bad++; $display("FAIL rst_no_done got=%b want=0", o_done); end
    end
    // Release and request on the same falling edge: the first rising edge must accept.
    rst = 1'b0;
    i_start = 1'b1;
    i_count = 4'd2;
    @(negedge clk);
    i_start = 1'b0;
    n_cmp++; if ({o_led, o_busy} !== 2'b11) begin n_bad++;
      $display("FAIL rst_first_edge got=%b want=11", {o_led, o_busy}); end
    observe(40, -1, 4'd0, busy_n, blinks, pat, got);
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL rst_rerun_timeout got=%0d want=1", got); end
    n_cmp++; if (busy_n !== 14 || blinks !== 2) begin n_bad++;
      $display("FAIL rst_rerun busy=%0d blinks=%0d want busy=14 blinks=2", busy_n, blinks); end
  endtask

  task automatic test_back_to_back;
    int b1, b2, k1, k2; logic [127:0] pat; bit g1, g2;
    start_seq(4'd1);
    observe(40, -1, 4'd0, b1, k1, pat, g1);
    i_start = 1'b1;
    i_count = 4'd1;
    @(negedge clk);
    i_start = 1'b0;
    n_cmp++; if ({o_led, o_busy, o_done} !== 3'b110) begin n_bad++;
      $display("FAIL b2b_restart got=%b want=110", {o_led, o_busy, o_done}); end
    observe(40, -1, 4'd0, b2, k2, pat, g2);
    n_cmp++; if (g1 !== 1'b1 || g2 !== 1'b1) begin n_bad++;
      $display("FAIL b2b_done_timeout got=%0d%0d want=11", g1, g2); end
    n_cmp++; if (b1 + b2 !== 18) begin n_bad++; $display("FAIL b2b_busy_total got=%0d want=18", b1 + b2); end
    n_cmp++; if (k1 + k2 !== 2) begin n_bad++; $display("FAIL b2b_blinks got=%0d want=2", k1 + k2); end
  endtask

  task automatic test_max_count;
    int busy_n, blinks; logic [127:0] pat; bit got;
    start_seq(4'd15);
    observe(200, 10, 4'd3, busy_n, blinks, pat, got);
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL max_done_timeout got=%0d want=1", got); end
    n_cmp++; if (blinks !== 15) begin n_bad++; $display("FAIL max_blinks got=%0d want=15", blinks); end
    n_cmp++; if (busy_n !== 79) begin n_bad++; $display("FAIL max_busy_len got=%0d want=79", busy_n); end
    @(negedge clk);
    n_cmp++; if (o_done !== 1'b0) begin n_bad++; $display("FAIL max_done_width got=%b want=0", o_done); end
  endtask

  initial begin
    test_reset();
    test_two_blinks();
    test_zero_count();
    test_ignore_start();
    test_async_reset();
    test_back_to_back();
    test_max_count();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
